seg_scan_driver: RTL and testbench

- Consumes the eight 4-bit digit values produced by the nibble circular shift register.
- Time-multiplexes them onto an 8-digit common-anode seven-segment display: one active anode at a time, plus hex-to-segment decode.
- Emits a once-per-frame pulse that the shift-register control uses as its shift_en source, so rotation happens only at frame boundaries.
- A shadow latch prevents a displayed frame from mixing digits from before and after a shift.

---
 rtl/seg_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//   Time-multiplexes eight 4-bit digit values onto an 8-digit common-anode
//   seven-segment display. One anode is active at a time. Each digit slot
//   lasts REFRESH_DIV clock cycles. A shadow copy of the digits and decimal
//   points is taken once per frame, so one displayed frame never mixes digits
//   from before and after an upstream shift. frame_tick pulses once per frame.
//   It is meant to drive the shift enable of the nibble circular shift
//   register that feeds seg0..seg7.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-low
//   en         in   1  scan enable; 0 = display dark, counters hold
//   seg0..seg7 in   4  digit values, seg0 = rightmost digit
//   dp_in      in   8  decimal point request per digit, active-high
//   blank_mask in   8  bit i = 1 forces digit i dark (live, not shadowed)
//   an         out  8  anode selects, active-low, bit i = digit i
//   sseg       out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick out  1  one-cycle pulse in the cycle a new frame begins
// ---------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] seg0,
   input  logic [3:0] seg1,
   input  logic [3:0] seg2,
   input  logic [3:0] seg3,
   input  logic [3:0] seg4,
   input  logic [3:0] seg5,
   input  logic [3:0] seg6,
   input  logic [3:0] seg7,
   input  logic [7:0] dp_in,
   input  logic [7:0] blank_mask,
   output logic [7:0] an,
   output logic [7:0] sseg,
   output logic       frame_tick
);

   localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          primed_q, primed_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [7:0]    shdp_q, shdp_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    sseg_q, sseg_d;
   logic          ft_q, ft_d;

   logic          tick;
   logic          frame_end;
   logic          load;
   logic [3:0]    cur_digit;

   // Hex to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick      = en & (cnt_q == CNT_LAST);
   assign frame_end = tick & (idx_q == 3'd7);
   // The first enabled cycle after reset fills the shadow. After that it
   // refreshes only at the frame boundary.
   assign load      = (en & ~primed_q) | frame_end;
   // The display reads the registered shadow. A load in this cycle takes
   // effect for the next frame, never for the digit being shown now.
   assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      primed_d = primed_q;
      shadow_d = shadow_q;
      shdp_d   = shdp_q;
      an_d     = 8'hFF;
      sseg_d   = 8'hFF;
      ft_d     = frame_end;

      if (en) begin
         if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (load) begin
         shadow_d = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
         shdp_d   = dp_in;
         primed_d = 1'b1;
      end

      if (en && !blank_mask[idx_q]) begin
         an_d   = ~(8'b1 << idx_q);
         sseg_d = {~shdp_q[idx_q], hex_to_seg(cur_digit)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         primed_q <= 1'b0;
         shadow_q <= 32'h0;
         shdp_q   <= 8'h00;
         an_q     <= 8'hFF;
         sseg_q   <= 8'hFF;
         ft_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         primed_q <= primed_d;
         shadow_q <= shadow_d;
         shdp_q   <= shdp_d;
         an_q     <= an_d;
         sseg_q   <= sseg_d;
         ft_q     <= ft_d;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIV = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_r;
  logic       en_r;
  logic [3:0] seg_r [8];
  logic [7:0] dp_r;
  logic [7:0] blank_r;
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst_r),
    .en         (en_r),
    .seg0       (seg_r[0]),
    .seg1       (seg_r[1]),
    .seg2       (seg_r[2]),
    .seg3       (seg_r[3]),
    .seg4       (seg_r[4]),
    .seg5       (seg_r[5]),
    .seg6       (seg_r[6]),
    .seg7       (seg_r[7]),
    .dp_in      (dp_r),
    .blank_mask (blank_r),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  int tests = 0;
  int fails = 0;

  // expected {an, sseg, frame_tick} after each rising edge
  logic [16:0] exp_q [$];

  logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] sseg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  function automatic logic [7:0] lut(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- predictor: counts enabled cycles since reset ----------------
  initial begin : predictor
    int         en_cycles;
    int         slot;
    int         pos;
    bit         primed;
    logic [3:0] sh [8];
    logic [7:0] sh_dp;
    logic [7:0] e_an, e_sseg;
    logic       e_ft;
    en_cycles = 0;
    primed    = 1'b0;
    sh_dp     = 8'h00;
    for (int i = 0; i < 8; i++) sh[i] = 4'h0;
    forever begin
      @(posedge clk);
      if (!rst_r) begin
        en_cycles = 0;
        primed    = 1'b0;
        sh_dp     = 8'h00;
        for (int i = 0; i < 8; i++) sh[i] = 4'h0;
        exp_q.push_back({8'hFF, 8'hFF, 1'b0});
      end else begin
        slot = (en_cycles / DIV) % 8;
        pos  = en_cycles % DIV;
        if (!en_r || blank_r[slot]) begin
          e_an   = 8'hFF;
          e_sseg = 8'hFF;
        end else begin
          e_an   = an_tab[slot];
          e_sseg = lut(sh[slot]);
          if (sh_dp[slot]) e_sseg[7] = 1'b0;
        end
        e_ft = en_r && (slot == 7) && (pos == DIV - 1);
        if (en_r && (!primed || e_ft)) begin
          for (int i = 0; i < 8; i++) sh[i] = seg_r[i];
          sh_dp  = dp_r;
          primed = 1'b1;
        end
        if (en_r) en_cycles++;
        exp_q.push_back({e_an, e_sseg, e_ft});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({an, sseg, frame_tick} !== e) begin
          fails++;
          $display("FAIL scan: got an=%h sseg=%h ft=%b expected an=%h sseg=%h ft=%b at %0t",
                   an, sseg, frame_tick, e[16:9], e[8:1], e[0], $time);
        end
      end
    end
  end

  // ---------------- stimulus with directed checks ----------------
  initial begin : stim
    logic [31:0] sr;
    logic        ft_now;
    sr      = 32'h0;
    rst_r   = 1'b0;
    en_r    = 1'b0;
    dp_r    = 8'h00;
    blank_r = 8'h00;
    for (int i = 0; i < 8; i++) seg_r[i] = 4'h0;

    repeat (3) @(negedge clk);
    check8("reset_an", an, 8'hFF);
    check8("reset_sseg", sseg, 8'hFF);
    check1("reset_ft", frame_tick, 1'b0);

    for (int i = 0; i < 8; i++) seg_r[i] = 4'(i);
    rst_r = 1'b1;
    en_r  = 1'b1;

    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      ft_now = frame_tick;

      // basic scan, one full frame
      if (k < 32) begin
        check8("basic_an", an, an_tab[k / 4]);
        check8("basic_sseg", sseg, sseg_tab[k / 4]);
      end
      if (k < 64) check1("basic_ft", frame_tick, (k == 31) || (k == 63));
      // tear-free frame
      if (k == 77) begin
        check8("tear_old_an", an, 8'hF7);
        check8("tear_old_sseg", sseg, 8'hB0);
      end
      if (k == 109) begin
        check8("tear_new_an", an, 8'hF7);
        check8("tear_new_sseg", sseg, 8'h8E);
      end
      // blank and dp
      if (k == 137) begin
        check8("blank_an", an, 8'hFF);
        check8("blank_sseg", sseg, 8'hFF);
      end
      if (k == 161) begin
        check8("dp_an", an, 8'hFE);
        check8("dp_sseg", sseg, 8'h40);
      end
      // enable gating
      if (k == 213) check8("gate_pre_an", an, 8'hDF);
      if (k >= 214 && k <= 223) begin
        check8("gate_dark_an", an, 8'hFF);
        check1("gate_no_ft", frame_tick, 1'b0);
      end
      if (k == 224 || k == 225) check8("gate_resume_an", an, 8'hDF);
      if (k == 226) check8("gate_next_an", an, 8'hBF);
      // after reset: slot 0 first, shadow reloaded from current inputs
      if (k == 231) begin
        check8("post_rst_an", an, 8'hFE);
        check8("post_rst_sseg", sseg, 8'h88);
      end
      if (k == 261) check1("post_rst_ft", frame_tick, 1'b1);
      // rotating register loop
      if (k == 295) check8("rot0_sseg", sseg, 8'hC0);
      if (k == 325) check1("rot_ft", frame_tick, 1'b1);
      if (k == 327) check8("rot1_sseg", sseg, 8'hF8);
      if (k == 359) check8("rot2_sseg", sseg, 8'h82);

      // stimulus applied here is seen by edge k+1
      if (k == 70) seg_r[3] = 4'hF;
      if (k == 127) begin
        blank_r = 8'h04;
        dp_r    = 8'h01;
      end
      if (k == 170) blank_r = 8'h00;
      if (k == 213) en_r = 1'b0;
      if (k == 223) en_r = 1'b1;
      if (k == 227) begin
        #2;
        rst_r = 1'b0;
        #1;
        check8("async_rst_an", an, 8'hFF);
        check8("async_rst_sseg", sseg, 8'hFF);
        check1("async_rst_ft", frame_tick, 1'b0);
        seg_r[0] = 4'hA;
        dp_r     = 8'h00;
      end
      if (k == 229) rst_r = 1'b1;
      if (k == 270) begin
        sr = 32'h76543210;
        for (int i = 0; i < 8; i++) seg_r[i] = sr[4*i +: 4];
      end
      if (k > 270 && ft_now) begin
        sr = {sr[27:0], sr[31:28]};
        for (int i = 0; i < 8; i++) seg_r[i] = sr[4*i +: 4];
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
